// File: rtl/dlx_branch_predictor.sv
// Direct-mapped branch predictor / BTB for the DLX fetch stage: registered
// lookup, saturating direction counters per entry, saturating statistics.
module dlx_branch_predictor #(
  parameter int PC_WIDTH   = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lookup_valid,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 pred_valid,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [PC_WIDTH-1:0]  pred_target,
  input  logic                 update_valid,
  input  logic [PC_WIDTH-1:0]  update_pc,
  input  logic                 update_taken,
  input  logic [PC_WIDTH-1:0]  update_target,
  input  logic                 update_pred_taken,
  input  logic [PC_WIDTH-1:0]  update_pred_target,
  input  logic                 flush,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] lookup_cnt,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0]                valid_q, valid_d;
  logic [ENTRIES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [ENTRIES-1:0][PC_WIDTH-1:0]  target_q, target_d;
  logic [ENTRIES-1:0][CTR_BITS-1:0]  ctr_q, ctr_d;

  logic                 pred_valid_q, pred_valid_d;
  logic                 pred_hit_q, pred_hit_d;
  logic                 pred_taken_q, pred_taken_d;
  logic [PC_WIDTH-1:0]  pred_target_q, pred_target_d;
  logic [CNT_WIDTH-1:0] lookup_cnt_q, lookup_cnt_d;
  logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

  logic [INDEX_BITS-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]      l_tag, u_tag;
  logic                  l_hit, l_taken, u_hit, mispredict;
  logic [1:0]            unused_pc_bits;

  assign unused_pc_bits = update_pc[1:0];

  assign l_idx = lookup_pc[INDEX_BITS+1:2];
  assign l_tag = lookup_pc[PC_WIDTH-1:INDEX_BITS+2];
  assign u_idx = update_pc[INDEX_BITS+1:2];
  assign u_tag = update_pc[PC_WIDTH-1:INDEX_BITS+2];

  // Lookup reads the registered table, so a same-cycle update or flush is not visible to it.
  assign l_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign l_taken = l_hit && ctr_q[l_idx][CTR_BITS-1];
  assign u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict = update_valid &&
                      ((update_taken != update_pred_taken) ||
                       (update_taken && (update_pred_target != update_target)));

  always_comb begin
    pred_valid_d  = lookup_valid;
    pred_hit_d    = pred_hit_q;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (lookup_valid) begin
      pred_hit_d    = l_hit;
      pred_taken_d  = l_taken;
      pred_target_d = l_taken ? target_q[l_idx] : lookup_pc + PC_WIDTH'(4);
    end
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (flush) begin
      valid_d = '0;
      ctr_d   = {ENTRIES{CTR_WNT}};
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken) begin
          target_d[u_idx] = update_target;
          if (ctr_q[u_idx] != CTR_MAX) ctr_d[u_idx] = ctr_q[u_idx] + CTR_BITS'(1);
        end else if (ctr_q[u_idx] != '0) begin
          ctr_d[u_idx] = ctr_q[u_idx] - CTR_BITS'(1);
        end
      end else if (update_taken) begin
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = update_target;
        ctr_d[u_idx]    = CTR_WT;
      end
    end
  end

  always_comb begin
    lookup_cnt_d     = lookup_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (clear_stats) begin
      lookup_cnt_d     = '0;
      mispredict_cnt_d = '0;
    end else begin
      if (lookup_valid && (lookup_cnt_q != '1))
        lookup_cnt_d = lookup_cnt_q + CNT_WIDTH'(1);
      if (mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q          <= '0;
      tag_q            <= '0;
      target_q         <= '0;
      ctr_q            <= {ENTRIES{CTR_WNT}};
      pred_valid_q     <= 1'b0;
      pred_hit_q       <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= '0;
      lookup_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      valid_q          <= valid_d;
      tag_q            <= tag_d;
      target_q         <= target_d;
      ctr_q            <= ctr_d;
      pred_valid_q     <= pred_valid_d;
      pred_hit_q       <= pred_hit_d;
      pred_taken_q     <= pred_taken_d;
      pred_target_q    <= pred_target_d;
      lookup_cnt_q     <= lookup_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_hit       = pred_hit_q;
  assign pred_taken     = pred_taken_q;
  assign pred_target    = pred_target_q;
  assign lookup_cnt     = lookup_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_dlx_branch_predictor.sv
// Directed bench for dlx_branch_predictor: a reference table model pushes expected
// predictions into a queue; they are popped when the registered prediction appears.
module tb_dlx_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        update_valid, update_taken, update_pred_taken;
  logic [31:0] update_pc, update_target, update_pred_target;
  logic        flush, clear_stats;
  logic [1:0]  lookup_cnt, mispredict_cnt;

  int errors = 0;
  int checks = 0;

  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  int          m_lk, m_mis;
  logic [33:0] sb [$];
  logic [33:0] last_exp;

  always #5 clk = ~clk;

  dlx_branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(4), .CTR_BITS(2), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target),
    .flush(flush), .clear_stats(clear_stats),
    .lookup_cnt(lookup_cnt), .mispredict_cnt(mispredict_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_lk = 0;
    m_mis = 0;
    last_exp = '0;
    sb.delete();
  endtask

  task automatic step(input bit lv, input logic [31:0] lpc,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt, input logic [31:0] uptgt,
                      input bit fl, input bit cs);
    int li, ui;
    bit h, t, uh;
    logic [33:0] e;
    lookup_valid = lv;  lookup_pc = lpc;
    update_valid = uv;  update_pc = upc;  update_taken = ut;
    update_target = utgt;  update_pred_taken = upt;  update_pred_target = uptgt;
    flush = fl;  clear_stats = cs;
    if (lv) begin
      li = int'(lpc[5:2]);
      h = m_valid[li] && (m_tag[li] == lpc[31:6]);
      t = h && (m_ctr[li] >= 2);
      sb.push_back({h, t, t ? m_tgt[li] : lpc + 32'd4});
    end
    if (cs) begin
      m_lk = 0;
      m_mis = 0;
    end else begin
      if (lv && m_lk < 3) m_lk++;
      if (uv && ((ut != upt) || (ut && (uptgt != utgt))) && m_mis < 3) m_mis++;
    end
    if (fl) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end else if (uv) begin
      ui = int'(upc[5:2]);
      uh = m_valid[ui] && (m_tag[ui] == upc[31:6]);
      if (uh && ut) begin
        m_tgt[ui] = utgt;
        if (m_ctr[ui] < 3) m_ctr[ui]++;
      end else if (uh) begin
        if (m_ctr[ui] > 0) m_ctr[ui]--;
      end else if (ut) begin
        m_valid[ui] = 1'b1;
        m_tag[ui]   = upc[31:6];
        m_tgt[ui]   = utgt;
        m_ctr[ui]   = 2;
      end
    end
    @(posedge clk);
    #1;
    chk("pred_valid", {31'd0, pred_valid}, {31'd0, lv});
    if (lv) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=pred expected=queued_entry");
      end else begin
        e = sb.pop_front();
        last_exp = e;
      end
    end
    chk("pred_hit", {31'd0, pred_hit}, {31'd0, last_exp[33]});
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, last_exp[32]});
    chk("pred_target", pred_target, last_exp[31:0]);
    chk("lookup_cnt", {30'd0, lookup_cnt}, m_lk);
    chk("mispredict_cnt", {30'd0, mispredict_cnt}, m_mis);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic update(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    // Predicted fields chosen to match the outcome so only deliberate cases mispredict.
    step(0, 0, 1, pc, t, tgt, t, tgt, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    lookup_valid = 0; lookup_pc = 0; update_valid = 0; update_pc = 0;
    update_taken = 0; update_target = 0; update_pred_taken = 0; update_pred_target = 0;
    flush = 0; clear_stats = 0;
    model_reset();
    #12;
    chk("rst_pred_valid", {31'd0, pred_valid}, 0);
    chk("rst_pred_hit", {31'd0, pred_hit}, 0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 0);
    chk("rst_pred_target", pred_target, 0);
    chk("rst_lookup_cnt", {30'd0, lookup_cnt}, 0);
    chk("rst_mispredict_cnt", {30'd0, mispredict_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    lookup(32'h100);
    chk("cold_hit", {31'd0, pred_hit}, 0);
    chk("cold_target", pred_target, 32'h104);
    chk("cold_lookup_cnt", {30'd0, lookup_cnt}, 1);

    step(0, 0, 1, 32'h100, 1, 32'h40, 0, 32'h104, 0, 0);
    lookup(32'h100);
    chk("alloc_hit", {31'd0, pred_hit}, 1);
    chk("alloc_taken", {31'd0, pred_taken}, 1);
    chk("alloc_target", pred_target, 32'h40);

    update(32'h100, 0, 0);  lookup(32'h100);
    update(32'h100, 0, 0);  lookup(32'h100);
    chk("nt2_taken", {31'd0, pred_taken}, 0);
    chk("nt2_target", pred_target, 32'h104);
    update(32'h100, 0, 0);  lookup(32'h100);
    update(32'h100, 1, 32'h40);  lookup(32'h100);
    chk("floor_one_taken", {31'd0, pred_taken}, 0);
    update(32'h100, 1, 32'h40);  lookup(32'h100);
    chk("t2_taken", {31'd0, pred_taken}, 1);
    for (int i = 0; i < 4; i++) begin
      update(32'h100, 1, 32'h40);  lookup(32'h100);
    end
    update(32'h100, 0, 0);  lookup(32'h100);
    chk("sat_nt_taken", {31'd0, pred_taken}, 1);
    chk("sat_nt_target", pred_target, 32'h40);

    lookup(32'h140);
    chk("alias_miss", {31'd0, pred_hit}, 0);
    update(32'h140, 1, 32'h80);
    lookup(32'h100);
    chk("alias_evict", {31'd0, pred_hit}, 0);
    lookup(32'h140);
    chk("alias_target", pred_target, 32'h80);

    step(1, 32'h200, 1, 32'h200, 1, 32'h300, 0, 32'h204, 0, 0);
    chk("same_cycle_miss", {31'd0, pred_hit}, 0);
    lookup(32'h200);
    chk("same_cycle_next_hit", {31'd0, pred_hit}, 1);
    chk("same_cycle_next_tgt", pred_target, 32'h300);

    step(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("flush_lookup_preflush", {31'd0, pred_hit}, 1);
    update(32'h200, 1, 32'h300);
    step(0, 0, 1, 32'h300, 1, 32'h500, 0, 0, 1, 0);
    lookup(32'h140);  chk("flush_miss_140", {31'd0, pred_hit}, 0);
    lookup(32'h200);  chk("flush_miss_200", {31'd0, pred_hit}, 0);
    lookup(32'h300);  chk("flush_miss_300", {31'd0, pred_hit}, 0);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++)
      step(0, 0, 1, 32'h400, 1, 32'h10, 1, 32'h20, 0, 0);
    chk("mis_saturate", {30'd0, mispredict_cnt}, 3);
    step(1, 32'h400, 1, 32'h400, 0, 0, 1, 32'h10, 0, 1);
    chk("clear_over_mis", {30'd0, mispredict_cnt}, 0);
    chk("clear_over_lookup", {30'd0, lookup_cnt}, 0);

    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lookup(32'hFFFF_FFFC);
    chk("wrap_target", pred_target, 32'h0);

    update(32'h100, 1, 32'h40);
    lookup(32'h100);
    lookup_valid = 1; lookup_pc = 32'h100;
    update_valid = 1; update_pc = 32'h500; update_taken = 1; update_target = 32'h60;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pred_valid", {31'd0, pred_valid}, 0);
    chk("midrst_pred_hit", {31'd0, pred_hit}, 0);
    chk("midrst_pred_taken", {31'd0, pred_taken}, 0);
    chk("midrst_pred_target", pred_target, 0);
    chk("midrst_lookup_cnt", {30'd0, lookup_cnt}, 0);
    chk("midrst_mispredict_cnt", {30'd0, mispredict_cnt}, 0);
    model_reset();
    lookup_valid = 0; update_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    lookup(32'h100);
    chk("post_rst_untrained", {31'd0, pred_hit}, 0);
    lookup(32'h500);
    chk("post_rst_no_alloc", {31'd0, pred_hit}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
